piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of data bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 shifts out din[WIDTH-1] first and 0 shifts out din[0] first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1 bit: din holds a word to load.
REQ-007 SHALL have port din_ready, output, 1 bit: the block accepts din at this edge.
REQ-008 SHALL have port b, output, 1 bit: the registered serial bit feeding the downstream sipo stage.
REQ-009 SHALL have port b_valid, output, 1 bit: b carries a frame bit this cycle.
REQ-010 SHALL have port b_last, output, 1 bit: b carries the final bit of the current frame.

Function
REQ-011 SHALL implement the states IDLE, SHIFT and PARITY (PARITY exists only when the parity macro is defined).
REQ-012 SHALL accept a word on any rising edge where din_valid=1 and din_ready=1 (the "load edge").
REQ-013 SHALL drive din_ready=1 in IDLE, in the last data-bit cycle of SHIFT when parity is off, and in the PARITY cycle when parity is on; otherwise 0.
REQ-014 SHALL hold din_ready=0 while rst=1.
REQ-015 SHALL, on the load edge, capture din, drive b=first bit and b_valid=1, and clear the bit counter, so the first bit appears in the cycle after the load edge (latency 1).
REQ-016 SHALL advance exactly one bit per clock in SHIFT, with no stall input; a frame has WIDTH data bits on consecutive cycles.
REQ-017 SHALL assert b_last with data bit WIDTH-1 when parity is off, and with the parity bit when parity is on.
REQ-018 SHALL, when a load occurs in a frame's final cycle, start the next frame on the very next cycle with no bubble (b_valid stays 1).
REQ-019 SHALL return to IDLE with b=0, b_valid=0, b_last=0 after the final bit when no load occurs in that cycle.
REQ-020 SHALL ignore din and din_valid whenever din_ready=0; the captured word is unaffected.
REQ-021 SHALL keep the bit counter at ceil(log2(WIDTH)) bits and never wrap it mid-frame.

Reset
REQ-022 SHALL, on rst=1, immediately force state=IDLE, b=0, b_valid=0, b_last=0, counter=0 and shift register=0, independent of clk.
REQ-023 SHALL abandon any frame in progress on reset mid-frame; the remaining bits are never emitted.
REQ-024 SHALL allow a load on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with PISO_PARITY_EN defined, append one even-parity bit (XOR of all WIDTH data bits) in the PARITY state after the data bits, with b_valid=1; frame length is WIDTH+1.
REQ-026 SHALL, without PISO_PARITY_EN, compile out the PARITY state and parity logic; frame length is WIDTH.

Structure
REQ-027 SHALL place the state typedef (IDLE/SHIFT/PARITY encoding) and the constant PISO_DEFAULT_WIDTH=4 in a shared package piso_pkg.
REQ-028 SHALL implement the bit counter with its terminal-count flag as the sub-module piso_bit_counter; the shift register and FSM stay in the top module.

Verification
REQ-029 Single word, WIDTH=4, MSB_FIRST=1, parity off: load 4'b1010 -> b=1,0,1,0 on cycles 1-4, b_last only on cycle 4, then b_valid=0; a downstream sipo stage then holds 4'b1010.
REQ-030 Back-to-back: din_valid held high with 4'b1100 then 4'b0011 -> 8 consecutive valid bits 1,1,0,0,0,0,1,1 with no gap; b_last on bits 4 and 8.
REQ-031 LSB-first (MSB_FIRST=0): load 4'b0001 -> b=1,0,0,0.
REQ-032 PISO_PARITY_EN defined: load 4'b0111 -> b=0,1,1,1 then parity bit 1, b_last on the parity bit; load 4'b0110 -> parity bit 0.
REQ-033 Reset mid-frame: assert rst asynchronously after bit 2 of 4'b1111 -> b and b_valid drop to 0 before the next edge; after release, 4'b0101 loads and serializes cleanly.
REQ-034 Backpressure: din_valid=1 with a new word during bit 2 of a frame -> din_ready=0 and the word is not taken until the frame's final cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso serializer slice (state encoding, default width).
// Latency: none, declarations only.
// Backpressure: n/a. The PARITY state is present only when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 4;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } piso_state_t;
`endif

    // Counter width ceil(log2(w)), never narrower than one bit.
    function automatic int piso_cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Data-bit index counter for one serializer frame, with terminal-count flag at WIDTH-1.
// Latency: count updates one cycle after clear/advance; tc is combinational from count.
// Backpressure: none; clear wins over advance, and the counter holds at WIDTH-1 until cleared.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             advance,
    output logic [piso_cnt_width(WIDTH)-1:0] count,
    output logic                             tc
);

    localparam int CW = piso_cnt_width(WIDTH);

    // Index of the data bit currently on b; cleared at each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count: the last data bit of the frame is on b.
    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer; optional even-parity bit when PISO_PARITY_EN is defined.
// Latency: first bit on b one cycle after the load edge; one bit per clock, no stall.
// Backpressure: din_ready only in IDLE or the frame's final cycle, so back-to-back frames have no bubble.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             b,
    output logic             b_valid,
    output logic             b_last
);

    localparam int CW = piso_cnt_width(WIDTH);

`ifdef PISO_PARITY_EN
    localparam bit PAR_ON = 1'b1;
    logic par;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             load;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

    assign load = din_valid & din_ready;

    // Bit ordering: shreg keeps the bits still to be sent, next one at the output end.
    assign first_bit  = MSB_FIRST ? din[WIDTH-1]   : din[0];
    assign load_rest  = MSB_FIRST ? (din << 1)     : (din >> 1);
    assign next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shift_rest = MSB_FIRST ? (shreg << 1)   : (shreg >> 1);

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .advance ((state == SHIFT) && !cnt_tc),
        .count   (cnt),
        .tc      (cnt_tc)
    );

    // Ready in IDLE and in the frame's final cycle only; never while reset is held.
    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    din_ready = 1'b1;
                SHIFT:   din_ready = cnt_tc && !PAR_ON;
`ifdef PISO_PARITY_EN
                PARITY:  din_ready = 1'b1;
`endif
                default: din_ready = 1'b0;
            endcase
        end
    end

    // Frame FSM with registered serial outputs; a load always starts a new frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            b       <= 1'b0;
            b_valid <= 1'b0;
            b_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (load) begin
            state   <= SHIFT;
            shreg   <= load_rest;
            b       <= first_bit;
            b_valid <= 1'b1;
            b_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            par     <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (!cnt_tc) begin
                        b      <= next_bit;
                        shreg  <= shift_rest;
                        b_last <= !PAR_ON && (cnt == CW'(WIDTH - 2));
                    end else begin
`ifdef PISO_PARITY_EN
                        state  <= PARITY;
                        b      <= par;
                        b_last <= 1'b1;
`else
                        state   <= IDLE;
                        b       <= 1'b0;
                        b_valid <= 1'b0;
                        b_last  <= 1'b0;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state   <= IDLE;
                    b       <= 1'b0;
                    b_valid <= 1'b0;
                    b_last  <= 1'b0;
                end
`endif
                default: begin
                    state   <= IDLE;
                    b       <= 1'b0;
                    b_valid <= 1'b0;
                    b_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share the same input stream.
// Latency: expects first bit one cycle after the load edge, one bit per cycle after that.
// Backpressure: checks din_ready low mid-frame and the held word taken only in the final cycle.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'b0000;
    logic       din_valid = 1'b0;

    logic rdy_m, b_m, bv_m, bl_m;
    logic rdy_l, b_l, bv_l, bl_l;

    int checks = 0;
    int errors = 0;

    // Downstream sipo model fed by the MSB-first instance; keeps the data bits only.
    logic [3:0] sipo = 4'b0000;
    int         sipo_n = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .b(b_m), .b_valid(bv_m), .b_last(bl_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .b(b_l), .b_valid(bv_l), .b_last(bl_l)
    );

    always #5 clk = ~clk;

    // Shift captured data bits into the sipo model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sipo_n <= 0;
        end else if (bv_m) begin
            if (sipo_n < 4) sipo <= {sipo[2:0], b_m};
            sipo_n <= bl_m ? 0 : sipo_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_rdy);
        chk({tag, " b_m"},   8'(b_m),   8'(0));
        chk({tag, " bv_m"},  8'(bv_m),  8'(0));
        chk({tag, " bl_m"},  8'(bl_m),  8'(0));
        chk({tag, " rdy_m"}, 8'(rdy_m), 8'(exp_rdy));
        chk({tag, " bv_l"},  8'(bv_l),  8'(0));
        chk({tag, " rdy_l"}, 8'(rdy_l), 8'(exp_rdy));
    endtask

    // Called with the first bit of a frame visible; leaves the run one edge past the final bit.
    // seqm/seql list emission order with the first bit at index 3; p is the hand-computed parity.
    task automatic check_frame(input string tag, input logic [3:0] seqm,
                               input logic [3:0] seql, input logic p);
        for (int i = 0; i < FL; i++) begin
            logic em, el, last;
            em   = (i < 4) ? seqm[3-i] : p;
            el   = (i < 4) ? seql[3-i] : p;
            last = (i == FL - 1);
            chk($sformatf("%s b_m[%0d]", tag, i),   8'(b_m),   8'(em));
            chk($sformatf("%s b_l[%0d]", tag, i),   8'(b_l),   8'(el));
            chk($sformatf("%s bv_m[%0d]", tag, i),  8'(bv_m),  8'(1));
            chk($sformatf("%s bv_l[%0d]", tag, i),  8'(bv_l),  8'(1));
            chk($sformatf("%s bl_m[%0d]", tag, i),  8'(bl_m),  8'(last));
            chk($sformatf("%s bl_l[%0d]", tag, i),  8'(bl_l),  8'(last));
            chk($sformatf("%s rdy_m[%0d]", tag, i), 8'(rdy_m), 8'(last));
            step();
        end
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk_idle("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset rdy", 8'(rdy_m), 8'(1));

        // Single word 1010 loaded on the first edge after reset release.
        din = 4'b1010; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check_frame("w1010", 4'b1010, 4'b0101, 1'b0);
        chk_idle("after1010", 1'b1);
        chk("sipo1010", 8'(sipo), 8'(4'b1010));

        // Back-to-back with backpressure: 0011 presented for the whole first frame.
        din = 4'b1100; din_valid = 1'b1;
        step();
        din = 4'b0011;
        check_frame("w1100", 4'b1100, 4'b0011, 1'b0);
        din_valid = 1'b0;
        din = 4'b1111;
        check_frame("w0011", 4'b0011, 4'b1100, 1'b0);
        chk_idle("after0011", 1'b1);
        chk("sipo0011", 8'(sipo), 8'(4'b0011));

        // Single set bit: LSB-first instance emits it first.
        din = 4'b0001; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check_frame("w0001", 4'b0001, 4'b1000, 1'b1);
        chk_idle("after0001", 1'b1);

        // Parity patterns (odd and even weight).
        din = 4'b0111; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check_frame("w0111", 4'b0111, 4'b1110, 1'b1);
        din = 4'b0110; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check_frame("w0110", 4'b0110, 4'b0110, 1'b0);
        chk_idle("after0110", 1'b1);

        // Reset mid-frame after bit 2 of 1111.
        din = 4'b1111; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("mid b1", 8'(b_m), 8'(1));
        step();
        chk("mid b2", 8'(b_m), 8'(1));
        #3 rst = 1'b1;
        #1;
        chk_idle("midrst", 1'b0);
        step();
        chk_idle("midrst edge", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        din = 4'b0101; din_valid = 1'b1;
        #1;
        chk("rel rdy", 8'(rdy_m), 8'(1));
        step();
        din_valid = 1'b0;
        check_frame("w0101", 4'b0101, 4'b1010, 1'b0);
        chk_idle("after0101", 1'b1);
        chk("sipo0101", 8'(sipo), 8'(4'b0101));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
